// File: rtl/seq_gen_multi.sv
// seq_gen_multi: one shared engine generating eight integer sequences with
// run control, valid/ready backpressure and sticky per-term overflow flags.
module seq_gen_multi #(
    parameter int WIDTH       = 8,
    parameter int IDX_W       = 8,
    parameter int STOP_ON_OVF = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [IDX_W-1:0] num_terms,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_ovf,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [2:0] md;
    logic [IDX_W-1:0] nt, idx, idx_n;
    logic [WIDTH-1:0] a, b, c, na, nb, nc, ia, ib, ic;
    logic fa, fb, fc, nfa, nfb, nfc, valid, last, last_n;
    logic [2*WIDTH-1:0] syl;
    logic [WIDTH+1:0] ab, x3, pell;
    logic [WIDTH:0] b1, b2;
    // a holds the presented term; b and c carry the lookahead terms or increments
    assign syl  = ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, a - WIDTH'(1)}) + (2*WIDTH)'(1);
    assign ab   = {2'b0, a} + {2'b0, b};
    assign x3   = {2'b0, a} + {1'b0, a, 1'b0};
    assign pell = {2'b0, a} + {1'b0, b, 1'b0};
    assign b1   = {1'b0, b} + (WIDTH+1)'(1);
    assign b2   = {1'b0, b} + (WIDTH+1)'(2);
    assign ia = (mode == 3'd0 || mode == 3'd4) ? WIDTH'(2) : (mode == 3'd5 || mode == 3'd6) ? '0 : WIDTH'(1);
    assign ib = (mode == 3'd1) ? WIDTH'(3) : (mode == 3'd0 || mode == 3'd2) ? '0 : WIDTH'(1);
    assign ic = WIDTH'(mode == 3'd3);
    always_comb begin
        na  = a;
        nb  = b;
        nc  = c;
        nfa = fa;
        nfb = fb;
        nfc = fc;
        case (md)
            3'd0: begin
                na  = syl[WIDTH-1:0];
                nfa = fa | (|syl[2*WIDTH-1:WIDTH]);
            end
            3'd1: begin
                na  = ab[WIDTH-1:0];
                nfa = fa | fb | (|ab[WIDTH+1:WIDTH]);
                nb  = b2[WIDTH-1:0];
                nfb = fb | b2[WIDTH];
            end
            3'd2: begin
                na  = x3[WIDTH-1:0];
                nfa = fa | (|x3[WIDTH+1:WIDTH]);
            end
            3'd3: begin
                na  = b;
                nb  = c;
                nc  = ab[WIDTH-1:0];
                nfa = fa | fb;
                nfb = fb | fc;
                nfc = fa | fb | (|ab[WIDTH+1:WIDTH]);
            end
            3'd5: begin
                na  = ab[WIDTH-1:0];
                nfa = fa | fb | (|ab[WIDTH+1:WIDTH]);
                nb  = b1[WIDTH-1:0];
                nfb = fb | b1[WIDTH];
            end
            3'd6: begin
                na  = b;
                nb  = pell[WIDTH-1:0];
                nfa = fa | fb;
                nfb = fa | fb | (|pell[WIDTH+1:WIDTH]);
            end
            default: begin
                na  = b;
                nb  = ab[WIDTH-1:0];
                nfa = fa | fb;
                nfb = fa | fb | (|ab[WIDTH+1:WIDTH]);
            end
        endcase
    end
    assign idx_n  = idx + IDX_W'(1);
    assign last_n = (nt != '0 && idx_n == nt - IDX_W'(1)) || (STOP_ON_OVF != 0 && nfa);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            md    <= '0;
            nt    <= '0;
            idx   <= '0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            fa    <= 1'b0;
            fb    <= 1'b0;
            fc    <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state <= RUN;
                    md    <= mode;
                    nt    <= num_terms;
                    idx   <= '0;
                    a     <= ia;
                    b     <= ib;
                    c     <= ic;
                    fa    <= 1'b0;
                    fb    <= 1'b0;
                    fc    <= 1'b0;
                    valid <= 1'b1;
                    last  <= num_terms == IDX_W'(1);
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    valid <= 1'b0;
                    last  <= 1'b0;
                end else if (valid && out_ready) begin
                    if (last) begin
                        state <= DONE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                    end else begin
                        a    <= na;
                        b    <= nb;
                        c    <= nc;
                        fa   <= nfa;
                        fb   <= nfb;
                        fc   <= nfc;
                        idx  <= idx_n;
                        last <= last_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign out_valid = valid;
    assign out_data  = a;
    assign out_index = idx;
    assign out_ovf   = fa;
    assign out_last  = last;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
endmodule

// File: tb/tb_seq_gen_multi.sv
// tb_seq_gen_multi: table of runs checked through a term scoreboard, plus
// hand-written reset, abort and start/abort collision sequences.
module tb_seq_gen_multi;
    logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [2:0] mode = '0;
    logic [7:0] num_terms = '0;
    logic v0, o0, l0, b0, dn0, v1, o1, l1, b1, dn1;
    logic [7:0] d0, i0, d1, i1;
    logic cv, co, cl, cb, cd;
    logic [7:0] cdata, cidx;
    int sel = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {logic [7:0] data; logic [7:0] idx; logic ovf; logic last;} term_t;
    typedef struct {int sel; logic [2:0] m; logic [7:0] n; int nchk; int rmode;} run_t;
    term_t sb[$];
    run_t runs[10];

    always #5 clk = ~clk;

    seq_gen_multi #(.WIDTH(8), .IDX_W(8), .STOP_ON_OVF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .mode(mode),
        .num_terms(num_terms), .out_valid(v0), .out_ready(ready), .out_data(d0),
        .out_index(i0), .out_ovf(o0), .out_last(l0), .busy(b0), .done(dn0));
    seq_gen_multi #(.WIDTH(8), .IDX_W(8), .STOP_ON_OVF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .mode(mode),
        .num_terms(num_terms), .out_valid(v1), .out_ready(ready), .out_data(d1),
        .out_index(i1), .out_ovf(o1), .out_last(l1), .busy(b1), .done(dn1));

    assign cv    = (sel != 0) ? v1 : v0;
    assign cdata = (sel != 0) ? d1 : d0;
    assign cidx  = (sel != 0) ? i1 : i0;
    assign co    = (sel != 0) ? o1 : o0;
    assign cl    = (sel != 0) ? l1 : l0;
    assign cb    = (sel != 0) ? b1 : b0;
    assign cd    = (sel != 0) ? dn1 : dn0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // True (unreduced) value of term k
    function automatic longint unsigned tv(input logic [2:0] m, input int k);
        longint unsigned x, y, z, t;
        case (m)
            3'd0: begin x = 2; for (int i = 0; i < k; i++) x = x * x - x + 1; return x; end
            3'd1: return longint'(k + 1) * longint'(k + 1);
            3'd2: begin x = 1; for (int i = 0; i < k; i++) x = x * 3; return x; end
            3'd3: begin
                x = 1; y = 1; z = 1;
                for (int i = 0; i < k; i++) begin t = x + y; x = y; y = z; z = t; end
                return x;
            end
            3'd4: begin x = 2; y = 1; for (int i = 0; i < k; i++) begin t = x + y; x = y; y = t; end return x; end
            3'd5: return longint'(k) * longint'(k + 1) / 2;
            3'd6: begin x = 0; y = 1; for (int i = 0; i < k; i++) begin t = 2 * y + x; x = y; y = t; end return x; end
            default: begin x = 1; y = 1; for (int i = 0; i < k; i++) begin t = x + y; x = y; y = t; end return x; end
        endcase
    endfunction

    task automatic run(input run_t r);
        longint unsigned t;
        logic so, fin;
        int cyc, stall;
        so = 1'b0;
        for (int k = 0; k < r.nchk; k++) begin
            t = tv(r.m, k);
            so = so | (t >= 256);
            sb.push_back('{data: t[7:0], idx: 8'(k), ovf: so,
                           last: (r.n != 0 && k == int'(r.n) - 1) || (r.sel != 0 && so)});
        end
        fin = sb[$].last;
        sel = r.sel;
        mode = r.m;
        num_terms = r.n;
        ready = 1'b0;
        if (r.sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        mode = ~r.m;
        num_terms = r.n + 8'd3;
        cyc = 0;
        stall = 0;
        while (sb.size() > 0 && cyc < 300) begin
            ready = (r.rmode == 0) ? 1'b1 : (r.rmode == 1) ? 1'($urandom_range(0, 1)) :
                    (cidx == 8'd4 && stall < 3) ? 1'b0 : 1'b1;
            if (r.rmode == 2 && !ready) stall++;
            chk("term", {cv, cdata, cidx, co, cl}, {1'b1, sb[0].data, sb[0].idx, sb[0].ovf, sb[0].last});
            if (ready) void'(sb.pop_front());
            @(negedge clk);
            cyc++;
        end
        if (sb.size() > 0) begin
            chk("run_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        ready = 1'b0;
        if (fin) begin
            chk("done_pulse", {cv, cb, cd}, {1'b0, 1'b1, 1'b1});
            @(negedge clk);
            chk("after_done", {cv, cb, cd}, 3'b000);
        end else begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_idle", {cv, cb, cd}, 3'b000);
            @(negedge clk);
            chk("abort_no_done", {cv, cb, cd}, 3'b000);
        end
    endtask

    initial begin
        runs[0] = '{0, 3'd7, 8'd0, 16, 0};
        runs[1] = '{0, 3'd6, 8'd8, 8, 1};
        runs[2] = '{0, 3'd4, 8'd14, 14, 1};
        runs[3] = '{0, 3'd1, 8'd17, 17, 0};
        runs[4] = '{0, 3'd2, 8'd8, 8, 2};
        runs[5] = '{0, 3'd3, 8'd1, 1, 0};
        runs[6] = '{1, 3'd0, 8'd0, 5, 1};
        runs[7] = '{0, 3'd0, 8'd4, 4, 1};
        runs[8] = '{0, 3'd5, 8'd0, 5, 0};
        runs[9] = '{0, 3'd3, 8'd0, 6, 0};
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset0", {v0, d0, i0, o0, l0, b0, dn0}, '0);
        chk("reset1", {v1, d1, i1, o1, l1, b1, dn1}, '0);
        foreach (runs[i]) run(runs[i]);
        start0 = 1'b1;
        abort = 1'b1;
        mode = 3'd7;
        @(negedge clk);
        start0 = 1'b0;
        abort = 1'b0;
        chk("start_abort", {v0, b0}, 2'b00);
        sel = 0;
        mode = 3'd1;
        num_terms = 8'd0;
        ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {v0, b0}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {v0, d0, i0, o0, l0, b0, dn0}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        chk("post_reset", {v0, b0, dn0}, 3'b000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
